fp_normalizer: RTL and testbench

- Post-add normalization stage that sits directly downstream of the 23-bit mantissa adder.
- Consumes the adder's raw sum, carry-out, hidden ("unseen") bit and sign, together with the aligned common exponent.
- Iteratively shifts the mantissa until the hidden bit is 1, adjusting the exponent on each shift, then packs an IEEE-754 single-precision word.
- Handles zero, overflow-to-infinity and gradual underflow to denormal.

---
 rtl/fp_pkg.sv | 38 +++
 rtl/fp_pack.sv | 41 ++++
 rtl/fp_normalizer.sv | 129 ++++++++++++
 tb/tb_fp_normalizer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared constants and types for the floating-point datapath stages.
// Holds the IEEE-754 single-precision field geometry, the normalizer state
// encoding and the working-register types used by fp_normalizer and fp_pack.
package fp_pkg;

    localparam int MANT_W  = 23;                     // stored mantissa bits
    localparam int EXP_W   = 8;                      // exponent field bits
    localparam int EXP_MAX = 255;                    // all-ones exponent (infinity)
    localparam int BIAS    = 127;

    localparam int WORD_W  = 1 + EXP_W + MANT_W;     // packed float width
    localparam int W_W     = MANT_W + 2;             // {carry, hidden, mant}
    localparam int E_W     = EXP_W + 2;              // signed working exponent

    // Packed-float field offsets
    localparam int SIGN_POS = WORD_W - 1;
    localparam int EXP_MSB  = WORD_W - 2;
    localparam int EXP_LSB  = MANT_W;
    localparam int MANT_MSB = MANT_W - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        PACK = 2'd2
    } state_t;

    typedef logic signed [E_W-1:0] exp_t;
    typedef logic [W_W-1:0]        work_t;

    localparam exp_t E_ONE = exp_t'(1);
    localparam exp_t E_INF = exp_t'(EXP_MAX);

    // Zero-extend a biased exponent field into the signed working exponent.
    function automatic exp_t widen_exp(input logic [EXP_W-1:0] e);
        return exp_t'({2'b00, e});
    endfunction

endpackage

// File: rtl/fp_pack.sv
// fp_pack: combinational assembly of a single-precision word.
// Ports:
//   sign    - result sign
//   exp_val - signed working exponent; only the low EXP_W bits are packed
//   w       - working mantissa {carry, hidden, mant}; only mant is packed
//   zero    - produce a signed zero
//   ovf     - produce a signed infinity
//   unf     - produce a denormal (exponent field 0, mantissa kept)
//   word    - packed {sign, exponent, mantissa}
module fp_pack
    import fp_pkg::*;
(
    input  logic              sign,
    input  exp_t              exp_val,
    input  work_t             w,
    input  logic              zero,
    input  logic              ovf,
    input  logic              unf,
    output logic [WORD_W-1:0] word
);

    // Carry/hidden bits and the exponent guard bits never reach the word.
    logic unused_bits;
    assign unused_bits = ^{w[W_W-1:MANT_W], exp_val[E_W-1:EXP_W]};

    always_comb begin
        word           = '0;
        word[SIGN_POS] = sign;
        if (zero) begin
            word[EXP_MSB:0] = '0;
        end else if (ovf) begin
            word[EXP_MSB:EXP_LSB] = '1;
        end else if (unf) begin
            word[MANT_MSB:0] = w[MANT_W-1:0];
        end else begin
            word[EXP_MSB:EXP_LSB] = exp_val[EXP_W-1:0];
            word[MANT_MSB:0]      = w[MANT_W-1:0];
        end
    end

endmodule

// File: rtl/fp_normalizer.sv
// fp_normalizer: post-add normalization stage behind the mantissa adder.
// Shifts the raw sum one bit per cycle until the hidden bit is set, tracking
// the exponent, then packs a single-precision word (truncating rounding).
// Ports:
//   clk       - rising-edge clock
//   rst       - asynchronous active-low reset
//   start     - one-cycle request, inputs sampled on this edge
//   mant_in   - adder sum bits
//   hidden_in - adder hidden-bit result
//   carry_in  - adder carry-out above the hidden bit
//   sign_in   - adder result sign
//   exp_in    - aligned biased exponent
//   busy      - high from the accepted start until done
//   done      - one-cycle pulse, result valid
//   result    - packed word, held until the next accepted start
//   zero_flag / ovf_flag / unf_flag - zero, infinity, denormal result
module fp_normalizer
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MANT_W-1:0] mant_in,
    input  logic              hidden_in,
    input  logic              carry_in,
    input  logic              sign_in,
    input  logic [EXP_W-1:0]  exp_in,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] result,
    output logic              zero_flag,
    output logic              ovf_flag,
    output logic              unf_flag
);

    state_t            state_reg;
    work_t             w_reg;
    exp_t              e_reg;
    logic              s_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              zero_reg;
    logic              ovf_reg;
    logic              unf_reg;
    logic [WORD_W-1:0] result_reg;
    logic [WORD_W-1:0] packed_word;
    exp_t              e_inc;

    assign e_inc = e_reg + E_ONE;

    fp_pack u_pack (
        .sign    (s_reg),
        .exp_val (e_reg),
        .w       (w_reg),
        .zero    (zero_reg),
        .ovf     (ovf_reg),
        .unf     (unf_reg),
        .word    (packed_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            w_reg      <= '0;
            e_reg      <= '0;
            s_reg      <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            zero_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
            unf_reg    <= 1'b0;
            result_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        w_reg     <= {carry_in, hidden_in, mant_in};
                        e_reg     <= widen_exp(exp_in);
                        s_reg     <= sign_in;
                        zero_reg  <= 1'b0;
                        ovf_reg   <= 1'b0;
                        unf_reg   <= 1'b0;
                        busy_reg  <= 1'b1;
                        state_reg <= NORM;
                    end
                end
                NORM: begin
                    if (w_reg == '0) begin
                        zero_reg  <= 1'b1;
                        state_reg <= PACK;
                    end else if (w_reg[W_W-1]) begin
                        // Carry set: shift right once (LSB dropped) and bump E.
                        w_reg <= w_reg >> 1;
                        e_reg <= e_inc;
                        if (e_inc >= E_INF) begin
                            ovf_reg   <= 1'b1;
                            state_reg <= PACK;
                        end
                    end else if (w_reg[MANT_W]) begin
                        state_reg <= PACK;
                    end else if (e_reg <= E_ONE) begin
                        // Exponent floor reached before normalizing: denormal.
                        unf_reg   <= 1'b1;
                        state_reg <= PACK;
                    end else begin
                        w_reg <= w_reg << 1;
                        e_reg <= e_reg - E_ONE;
                    end
                end
                PACK: begin
                    result_reg <= packed_word;
                    done_reg   <= 1'b1;
                    busy_reg   <= 1'b0;
                    state_reg  <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign result    = result_reg;
    assign zero_flag = zero_reg;
    assign ovf_flag  = ovf_reg;
    assign unf_flag  = unf_reg;

endmodule

// File: tb/tb_fp_normalizer.sv
module tb_fp_normalizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [22:0] mant_in;
    logic        hidden_in;
    logic        carry_in;
    logic        sign_in;
    logic [7:0]  exp_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zero_flag;
    logic        ovf_flag;
    logic        unf_flag;

    int checks = 0;
    int errors = 0;

    // flags ordering: {zero, ovf, unf}
    typedef struct {
        string       name;
        logic        c;
        logic        h;
        logic [22:0] m;
        logic        s;
        logic [7:0]  e;
        logic [31:0] xr;
        logic [2:0]  xf;
        int          xl;
    } vec_t;

    vec_t sb_q[$];

    always #5 clk = ~clk;

    fp_normalizer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mant_in   (mant_in),
        .hidden_in (hidden_in),
        .carry_in  (carry_in),
        .sign_in   (sign_in),
        .exp_in    (exp_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .zero_flag (zero_flag),
        .ovf_flag  (ovf_flag),
        .unf_flag  (unf_flag)
    );

    function automatic vec_t mk(input string n, input logic c, input logic h,
                                input logic [22:0] m, input logic s, input logic [7:0] e,
                                input logic [31:0] xr, input logic [2:0] xf, input int xl);
        vec_t v;
        v.name = n; v.c = c; v.h = h; v.m = m; v.s = s; v.e = e;
        v.xr = xr; v.xf = xf; v.xl = xl;
        return v;
    endfunction

    // Pulse start for one edge with the vector's inputs; expectation is queued.
    task automatic drive(input vec_t v);
        sb_q.push_back(v);
        carry_in  = v.c;
        hidden_in = v.h;
        mant_in   = v.m;
        sign_in   = v.s;
        exp_in    = v.e;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait (bounded) for done; lat counts edges after the start edge, -1 on timeout.
    task automatic collect(input int base, output logic [31:0] r, output logic [2:0] f,
                           output int lat);
        lat = -1;
        r   = 'x;
        f   = 'x;
        for (int i = base + 1; i <= base + 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = i;
                r   = result;
                f   = {zero_flag, ovf_flag, unf_flag};
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; mant_in = '0; hidden_in = 1'b0;
        carry_in = 1'b0; sign_in = 1'b0; exp_in = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, result, zero_flag, ovf_flag, unf_flag} !== 37'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h required=0",
                     {busy, done, result, zero_flag, ovf_flag, unf_flag});
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL post_reset_idle busy/done got=%b required=00", {busy, done});
        end
        $display("txn reset: outputs cleared");
    endtask

    task automatic test_shifts();
        vec_t tbl[$];
        vec_t x;
        logic [31:0] r;
        logic [2:0] f;
        int l;
        tbl.push_back(mk("rshift", 1, 1, 23'h000000, 0, 8'h7F, 32'h40400000, 3'b000, 3));
        tbl.push_back(mk("noshift", 0, 1, 23'h400000, 0, 8'h80, 32'h40400000, 3'b000, 2));
        tbl.push_back(mk("lshift3", 0, 0, 23'h100000, 1, 8'h85, 32'hC1000000, 3'b000, 5));
        tbl.push_back(mk("trunc", 1, 1, 23'h000001, 1, 8'h7F, 32'hC0400000, 3'b000, 3));
        foreach (tbl[k]) begin
            drive(tbl[k]);
            collect(0, r, f, l);
            x = sb_q.pop_front();
            checks++;
            if (r !== x.xr) begin errors++; $display("FAIL %s result got=%h required=%h", x.name, r, x.xr); end
            checks++;
            if (f !== x.xf) begin errors++; $display("FAIL %s flags got=%b required=%b", x.name, f, x.xf); end
            checks++;
            if (l !== x.xl) begin errors++; $display("FAIL %s latency got=%0d required=%0d", x.name, l, x.xl); end
            $display("txn %s result=%h flags=%b latency=%0d", x.name, r, f, l);
        end
    endtask

    task automatic test_zero_ovf();
        vec_t tbl[$];
        vec_t x;
        logic [31:0] r;
        logic [2:0] f;
        int l;
        tbl.push_back(mk("zero", 0, 0, 23'h000000, 0, 8'h40, 32'h00000000, 3'b100, 2));
        tbl.push_back(mk("zero_neg", 0, 0, 23'h000000, 1, 8'h90, 32'h80000000, 3'b100, 2));
        tbl.push_back(mk("ovf", 1, 0, 23'h000000, 0, 8'hFE, 32'h7F800000, 3'b010, 2));
        foreach (tbl[k]) begin
            drive(tbl[k]);
            collect(0, r, f, l);
            x = sb_q.pop_front();
            checks++;
            if (r !== x.xr) begin errors++; $display("FAIL %s result got=%h required=%h", x.name, r, x.xr); end
            checks++;
            if (f !== x.xf) begin errors++; $display("FAIL %s flags got=%b required=%b", x.name, f, x.xf); end
            checks++;
            if (l !== x.xl) begin errors++; $display("FAIL %s latency got=%0d required=%0d", x.name, l, x.xl); end
            $display("txn %s result=%h flags=%b latency=%0d", x.name, r, f, l);
        end
    endtask

    task automatic test_underflow();
        vec_t tbl[$];
        vec_t x;
        logic [31:0] r;
        logic [2:0] f;
        int l;
        tbl.push_back(mk("unf", 0, 0, 23'h000010, 0, 8'h03, 32'h00000040, 3'b001, 4));
        tbl.push_back(mk("unf_exp0", 0, 0, 23'h000001, 0, 8'h00, 32'h00000001, 3'b001, 2));
        foreach (tbl[k]) begin
            drive(tbl[k]);
            collect(0, r, f, l);
            x = sb_q.pop_front();
            checks++;
            if (r !== x.xr) begin errors++; $display("FAIL %s result got=%h required=%h", x.name, r, x.xr); end
            checks++;
            if (f !== x.xf) begin errors++; $display("FAIL %s flags got=%b required=%b", x.name, f, x.xf); end
            checks++;
            if (l !== x.xl) begin errors++; $display("FAIL %s latency got=%0d required=%0d", x.name, l, x.xl); end
            $display("txn %s result=%h flags=%b latency=%0d", x.name, r, f, l);
        end
    endtask

    task automatic test_back_to_back();
        vec_t x;
        logic [31:0] r;
        logic [2:0] f;
        int l;
        // Second start is raised in the done cycle of the first.
        drive(mk("b2b_a", 0, 0, 23'h100000, 1, 8'h85, 32'hC1000000, 3'b000, 5));
        for (int k = 0; k < 2; k++) begin
            collect(0, r, f, l);
            if (k == 0) drive(mk("b2b_b", 1, 1, 23'h000000, 0, 8'h7F, 32'h40400000, 3'b000, 3));
            if (sb_q.size() == 0) begin
                errors++; checks++;
                $display("FAIL b2b scoreboard empty got=0 entries required=1");
            end else begin
                x = sb_q.pop_front();
                checks++;
                if (r !== x.xr) begin errors++; $display("FAIL %s result got=%h required=%h", x.name, r, x.xr); end
                checks++;
                if (f !== x.xf) begin errors++; $display("FAIL %s flags got=%b required=%b", x.name, f, x.xf); end
                checks++;
                if (l !== x.xl) begin errors++; $display("FAIL %s latency got=%0d required=%0d", x.name, l, x.xl); end
                $display("txn %s result=%h flags=%b latency=%0d", x.name, r, f, l);
            end
        end
    endtask

    task automatic test_ignored_start();
        vec_t x;
        logic [31:0] r;
        logic [2:0] f;
        int l;
        int extra;
        drive(mk("ign", 0, 0, 23'h100000, 1, 8'h85, 32'hC1000000, 3'b000, 5));
        @(posedge clk);
        #1;
        // Stray request with inputs that would produce a zero result.
        carry_in = 1'b0; hidden_in = 1'b0; mant_in = '0; sign_in = 1'b0; exp_in = '0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        collect(2, r, f, l);
        x = sb_q.pop_front();
        checks++;
        if (r !== x.xr) begin errors++; $display("FAIL %s result got=%h required=%h", x.name, r, x.xr); end
        checks++;
        if (f !== x.xf) begin errors++; $display("FAIL %s flags got=%b required=%b", x.name, f, x.xf); end
        checks++;
        if (l !== x.xl) begin errors++; $display("FAIL %s latency got=%0d required=%0d", x.name, l, x.xl); end
        extra = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin errors++; $display("FAIL ign_extra_activity got=%0d cycles required=0", extra); end
        checks++;
        if (result !== 32'hC1000000) begin errors++; $display("FAIL ign_result_held got=%h required=C1000000", result); end
        $display("txn %s result=%h flags=%b latency=%0d", x.name, r, f, l);
    endtask

    task automatic test_reset_midop();
        vec_t x;
        logic [31:0] r;
        logic [2:0] f;
        int l;
        int seen;
        drive(mk("abort", 0, 0, 23'h100000, 1, 8'h85, 32'hC1000000, 3'b000, 5));
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, done, result, zero_flag, ovf_flag, unf_flag} !== 37'd0) begin
            errors++;
            $display("FAIL midop_reset_outputs got=%h required=0",
                     {busy, done, result, zero_flag, ovf_flag, unf_flag});
        end
        void'(sb_q.pop_front());
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL midop_no_done got=%0d pulses required=0", seen); end
        $display("txn abort: reset during NORM, done pulses=%0d", seen);
        drive(mk("after_rst", 0, 1, 23'h400000, 0, 8'h80, 32'h40400000, 3'b000, 2));
        collect(0, r, f, l);
        x = sb_q.pop_front();
        checks++;
        if (r !== x.xr) begin errors++; $display("FAIL %s result got=%h required=%h", x.name, r, x.xr); end
        checks++;
        if (f !== x.xf) begin errors++; $display("FAIL %s flags got=%b required=%b", x.name, f, x.xf); end
        checks++;
        if (l !== x.xl) begin errors++; $display("FAIL %s latency got=%0d required=%0d", x.name, l, x.xl); end
        $display("txn %s result=%h flags=%b latency=%0d", x.name, r, f, l);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got=running required=finished");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_shifts();
        test_zero_ovf();
        test_underflow();
        test_back_to_back();
        test_ignored_start();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
